// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute ALU with a registered one-entry output stage.
// Optional feature macro: ALU_MUL_EN enables the multi-cycle signed multiply
// (opcode 1011). Without it, 1011 completes in one cycle with err=1.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       instruction,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             jump,
    output logic             overflow,
    output logic             err
);
    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             jump;
        logic             ovf;
        logic             err;
    } res_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    res_t             res_q, alu_res, mul_res;
    logic             live;
    logic             accept, start_mul, mul_done;
    logic [3:0]       opc, imm4;
    logic [WIDTH-1:0] imm4s, sum;
    logic [31:0]      sh;

    assign opc  = instruction[7:4];
    assign imm4 = instruction[3:0];

    // live holds off acceptance until the first edge after reset release
    assign in_ready = live && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle result for the current request
    always_comb begin
        alu_res = '0;
        imm4s   = WIDTH'($signed(imm4));
        sh      = 32'(imm4) % WIDTH;
        sum     = in0 + in1;
        case (opc)
            4'h0: alu_res.val = in0;
            4'h1: begin
                alu_res.val = sum;
                alu_res.ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
            end
            4'h2: alu_res.val = in0 & in1;
            4'h3: alu_res.val = ~in0;
            4'h4: alu_res.val = ~(in0 | in1);
            4'h5: alu_res.val = WIDTH'($signed(in0) < $signed(in1));
            4'h6: alu_res.val = in1 << sh;
            4'h7: alu_res.val = in1 >> sh;
            4'h8, 4'h9: begin
                alu_res.val  = in1 - pc - ONE;
                alu_res.jump = 1'b1;
            end
            4'hA: alu_res.val = sum;
            4'hB: begin
`ifdef ALU_MUL_EN
                alu_res.err = 1'b0;
`else
                alu_res.err = 1'b1;
`endif
            end
            4'hC: alu_res.jump = (in0 == in1);
            4'hD: alu_res.jump = (in0 != in1);
            4'hE: alu_res.val  = in1 + imm4s;
            default: alu_res.val = imm4s;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [WIDTH:0]     macc, booth_sum, nxt_acc;
    logic [WIDTH-1:0]   mq, mcand, nxt_q;
    logic               mq1;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;

    assign start_mul = accept && (opc == 4'hB);
    assign mul_done  = (state == MUL) && (cnt == CNT_W'(1));

    // Booth radix-2 step; accumulator carries one guard bit so -M never overflows
    always_comb begin
        booth_sum = macc;
        case ({mq[0], mq1})
            2'b01:   booth_sum = macc + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = macc - {mcand[WIDTH-1], mcand};
            default: booth_sum = macc;
        endcase
        nxt_acc     = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        nxt_q       = {booth_sum[0], mq[WIDTH-1:1]};
        prod        = {nxt_acc[WIDTH-1:0], nxt_q};
        mul_res     = '0;
        mul_res.val = prod[WIDTH-1:0];
        mul_res.ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    end

    // Multiplier registers: load on accept, one shift-add per MUL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            macc  <= '0;
            mq    <= '0;
            mq1   <= 1'b0;
            mcand <= '0;
            cnt   <= '0;
        end else if (start_mul) begin
            macc  <= '0;
            mq    <= in1;
            mq1   <= 1'b0;
            mcand <= in0;
            cnt   <= CNT_W'(WIDTH);
        end else if (state == MUL) begin
            macc  <= nxt_acc;
            mq    <= nxt_q;
            mq1   <= mq[0];
            cnt   <= cnt - CNT_W'(1);
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: IDLE -> MUL on a multiply accept, back when the last step lands
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mul) state_nxt = MUL;
            MUL:     if (mul_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage: holds until handoff; a same-edge accept refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            out_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            live <= 1'b1;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && !start_mul) begin
                out_valid <= 1'b1;
                res_q     <= alu_res;
            end else if (mul_done) begin
                out_valid <= 1'b1;
                res_q     <= mul_res;
            end
        end
    end

    assign out      = res_q.val;
    assign jump     = res_q.jump;
    assign overflow = res_q.ovf;
    assign err      = res_q.err;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit execute ALU. It accepts one instruction plus operands per transfer over a valid/ready interface and computes the result of the 4-bit opcode set. It returns the result through a one-entry registered output stage with backpressure. Multiply is an optional multi-cycle operation. The block sits between register-read and writeback/branch-resolve in the core datapath.

## Interface
- WIDTH, 8, datapath width for in0, in1, pc, out (≥4)
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept this cycle
- instruction  in  8  [7:4] opcode, [3:0] imm4
- pc  in  WIDTH  program counter of the instruction
- in0  in  WIDTH  first operand
- in1  in  WIDTH  second operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- jump  out  1  branch/jump taken
- overflow  out  1  signed overflow
- err  out  1  unsupported opcode (MUL compiled out)

## Operation
- Accept = in_valid & in_ready; operands and instruction are captured only on accept.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- Results: jump=0, overflow=0, err=0 unless stated. imm4s = imm4 sign-extended to WIDTH. sh = imm4 mod WIDTH.
  - 0000 MOVE: out=in0.
  - 0001 ADD: out=in0+in1 (mod 2^WIDTH). overflow=1 iff the operand signs are equal and the result sign differs.
  - 0010 AND: out=in0&in1.
  - 0011 NOT: out=~in0.
  - 0100 NOR: out=~(in0|in1).
  - 0101 SLT: out=1 if $signed(in0)<$signed(in1), else 0.
  - 0110 SLL: out=in1<<sh.
  - 0111 SRL: out=in1>>sh (logical).
  - 1000 J and 1001 JAL: out=in1-pc-1; jump=1.
  - 1010 LSADDR: out=in0+in1 (load/store address), no overflow.
  - 1011 MUL: out=low WIDTH bits of the signed product in0*in1. overflow=1 iff the full 2·WIDTH signed product ≠ sign-extension of out.
  - 1100 BEQ: jump=(in0==in1); out=0.
  - 1101 BNE: jump=(in0!=in1); out=0.
  - 1110 ADDI: out=in1+imm4s.
  - 1111 LI: out=imm4s.
- FSM: IDLE, MUL.
  - IDLE: on accept of a non-MUL opcode, register the result and set out_valid next edge.
  - IDLE: on accept of MUL, go to MUL and load the multiplicand, multiplier and count=WIDTH.
  - MUL: one shift-add step per cycle (Booth radix-2 or equivalent signed algorithm); count decrements. When count reaches 0, register the result, set out_valid and return to IDLE.
- out_valid stays high and out/jump/overflow/err stay stable until out_ready is seen high while out_valid is high. out_valid clears on that edge unless a new single-cycle accept occurs on the same edge, in which case it stays high with the new result.

## Timing
- Reset (async assert, sync release): state=IDLE, out_valid=0, out=0, jump=0, overflow=0, err=0, counter=0.
- Single-cycle ops: accept at edge N, out_valid=1 after edge N+1. Full throughput of 1/cycle when out_ready is held high.
- MUL: accept at edge N, out_valid=1 after edge N+WIDTH+1. in_ready=0 from edge N+1 until the result is valid.
- Backpressure: while out_valid & !out_ready, in_ready=0 and nothing is accepted.
- Reset asserted mid-MUL aborts immediately. No result is produced after release.
- WIDTH-bit wrap-around on all arithmetic. pc-relative jumps wrap modulo 2^WIDTH.

## Configuration
- ALU_MUL_EN defined: opcode 1011 performs the multi-cycle MUL above.
- ALU_MUL_EN undefined: the MUL state, counter and shift-add datapath are removed. Opcode 1011 completes as a single-cycle op with out=0, overflow=0, jump=0, err=1.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, in_ready=0, all outputs 0. Release → in_ready=1 and no spurious output.
- ADD overflow, WIDTH=8: 0x7F+0x01 → out=0x80, overflow=1. 0xFF+0x01 → out=0x00, overflow=0. Each result valid one cycle after accept.
- Back-to-back throughput with out_ready=1: ten ops (AND, NOR, SLT -1<1 → 1, SLL in1=0x03 imm=2 → 0x0C) → ten results on consecutive cycles, in order.
- Backpressure: hold out_ready=0 after one result → out stable, in_ready=0, the next request waits. Set out_ready=1 → handoff completes and the next request is accepted on the same edge.
- Branch/jump: BEQ 5,5 → jump=1. BNE 5,5 → jump=0. J pc=3, in1=7 → out=3, jump=1.
- MUL (ALU_MUL_EN): 0xFD·0x04 → out=0xF4 (-12), overflow=0, valid 9 cycles after accept. 0x40·0x04 → overflow=1. Reset pulse mid-MUL → no result. Without the macro: 1011 → err=1, out=0 after 1 cycle.
